kfpga_config_loader: RTL and testbench
======================================

Name: kfpga_config_loader

Overview:
- Sequential bitstream loader that drives CHAINS parallel configuration shift chains of a kFPGA core.
- Generalises the core's single serial config chain: the bitstream can be split across several chains that shift in lockstep.
- Accepts a valid/ready bit-slice stream, clears the fabric, shifts exactly CHAIN_LENGTH slices, then releases the fabric.
- Sits between the bitstream source (SPI/host FIFO) and the core's config_in/config_enable/config_nreset pins. The core's config_clock is tied to this block's clock.

Parameters:
- CHAINS, 4, number of parallel config chains; also the bitstream slice width.
- CHAIN_LENGTH, 1024, config bits per chain; must be >= 1.
- CLEAR_CYCLES, 4, cycles config_nreset is held low before loading; must be >= 1.

Ports:
- clock  in  1  single clock; the core's config_clock is driven from the same net.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a (re)configuration.
- abort  in  1  one-cycle pulse; cancels a load in progress.
- bs_data  in  CHAINS  bitstream slice; bit i goes to chain i.
- bs_valid  in  1  bs_data valid.
- bs_ready  out  1  loader accepts a slice this cycle.
- config_data  out  CHAINS  serial data into each chain head.
- config_enable  out  1  shift-enable to all chains.
- config_nreset  out  1  active-low clear of the fabric config registers.
- chain_tail  in  CHAINS  chain tail outputs; used only with the optional feature, otherwise ignored.
- busy  out  1  high in CLEAR, LOAD and VERIFY.
- done  out  1  configuration complete; fabric released.
- error  out  1  readback mismatch (optional feature only).
- bit_count  out  $clog2(CHAIN_LENGTH+1)  slices shifted so far.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; bs_ready=0, config_data=0, config_enable=0, config_nreset=0, busy=0, done=0, error=0, bit_count=0. All outputs are registered.
- State IDLE: fabric held cleared (config_nreset=0). start -> CLEAR.
- State CLEAR: config_nreset=0 for exactly CLEAR_CYCLES cycles, counted from the first CLEAR cycle, then -> LOAD. bit_count is zeroed on entry.
- State LOAD:
  - config_nreset=1; bs_ready=1 while bit_count < CHAIN_LENGTH.
  - On a handshake (bs_valid && bs_ready): config_data <= bs_data and config_enable <= 1 in the next cycle, a single-cycle pulse; bit_count increments.
  - With no handshake, config_enable=0 and config_data holds its value.
  - bs_ready drops in the cycle after the CHAIN_LENGTH-th handshake; exactly CHAIN_LENGTH enable pulses are issued.
  - After the last pulse -> DONE, or -> VERIFY when the macro is defined.
- State DONE: done=1, config_nreset=1, bs_ready=0. start -> CLEAR (reconfiguration); done falls on that transition.
- State ERROR (macro only): error=1, config_nreset=0 (fabric held cleared). start -> CLEAR clears error; abort -> IDLE clears error.
- abort in CLEAR, LOAD or VERIFY -> IDLE next cycle, with config_enable=0 and config_nreset=0. Same-cycle start+abort: abort wins. start in CLEAR/LOAD/VERIFY is ignored.
- Reset mid-load: immediate return to reset values; the partial bitstream is discarded because the fabric is held cleared.
- bit_count saturates at CHAIN_LENGTH and never wraps.

Optional Feature:
- Macro: KFPGA_CONFIG_READBACK_EN.
- Defined:
  - During LOAD, each config_enable pulse samples chain_tail in the same cycle. Any 1 seen before CHAIN_LENGTH pulses have been issued means the chain was not cleared or is too short -> ERROR.
  - Per-chain ones-counters accumulate the loaded bits.
  - VERIFY recirculates: config_data=chain_tail, config_enable=1 for CHAIN_LENGTH cycles, counting ones per chain from chain_tail. This restores the configuration unchanged.
  - Any count mismatch -> ERROR; otherwise -> DONE.
- Undefined: no VERIFY or ERROR state, error tied 0, chain_tail unused; LOAD goes directly to DONE.

Decomposition:
- Package kfpga_config_pkg: state enum (IDLE, CLEAR, LOAD, VERIFY, DONE, ERROR) and a count-width function $clog2(n+1).
- One sub-module, kfpga_config_chain_checker, instantiated per chain under the macro: holds the load and readback ones-counters and the compare logic.

Test Plan:
- CHAINS=2, CHAIN_LENGTH=8, CLEAR_CYCLES=4; start; bs_valid held high with slices 0..7 -> config_nreset low 4 cycles; then exactly 8 config_enable pulses with config_data = each slice, one cycle after each handshake; done=1 after the 8th pulse; bit_count=8.
- Same configuration, bs_valid toggling every other cycle -> 8 handshakes over ~16 cycles; config_enable pulses only after handshakes; no extra or missing shifts.
- abort after 3 slices -> IDLE next cycle; config_nreset=0, busy=0, done=0; a following start reloads the full 8 slices.
- Reset asserted mid-LOAD, together with same-cycle start+abort in CLEAR -> all outputs at reset values / abort wins, state IDLE.
- Macro on, behavioural 8-bit chain model: good load -> DONE with error=0 and chain contents unchanged after VERIFY; chain model stuck with a tail bit of 1 -> ERROR with error=1, config_nreset=0; start clears error.

Source files
------------

// File: rtl/kfpga_config_pkg.sv
// kFPGA configuration loader shared definitions.
// Loader state encoding and the counter-width helper.
package kfpga_config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        VERIFY,
        DONE,
        ERROR
    } state_e;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/kfpga_config_chain_checker.sv
// Per-chain readback checker: counts ones shifted in during load and
// ones seen at the chain tail during recirculation, and compares them.
// Ports: clock/reset; clear zeroes both counters; load_en/load_bit count
// loaded bits; rb_en counts tail_bit; tail_err flags a 1 at the tail
// during load; mismatch flags differing counts.
module kfpga_config_chain_checker
    import kfpga_config_pkg::*;
#(
    parameter int CHAIN_LENGTH = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic load_en,
    input  logic load_bit,
    input  logic rb_en,
    input  logic tail_bit,
    output logic tail_err,
    output logic mismatch
);

    localparam int CW = cnt_width(CHAIN_LENGTH);

    logic [CW-1:0] load_ones_q, load_ones_d;
    logic [CW-1:0] rb_ones_q, rb_ones_d;

    always_comb begin
        load_ones_d = load_ones_q;
        rb_ones_d   = rb_ones_q;
        if (clear) begin
            load_ones_d = '0;
            rb_ones_d   = '0;
        end else begin
            if (load_en) load_ones_d = load_ones_q + CW'(load_bit);
            if (rb_en)   rb_ones_d   = rb_ones_q + CW'(tail_bit);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            load_ones_q <= '0;
            rb_ones_q   <= '0;
        end else begin
            load_ones_q <= load_ones_d;
            rb_ones_q   <= rb_ones_d;
        end
    end

    // A cleared chain of the right length only ever shifts out zeros
    // while the new bitstream is being pushed in.
    assign tail_err = load_en && tail_bit;
    assign mismatch = (load_ones_q != rb_ones_q);

endmodule

// File: rtl/kfpga_config_loader.sv
// Bitstream loader for CHAINS parallel kFPGA config chains: clears the
// fabric, shifts CHAIN_LENGTH slices from a valid/ready stream, releases.
// Ports: clock, reset (sync, active-high), start/abort pulses;
// bs_data/bs_valid/bs_ready stream in; config_data/config_enable/
// config_nreset to the core; chain_tail readback; busy/done/error/bit_count.
// Optional macro KFPGA_CONFIG_READBACK_EN adds VERIFY/ERROR readback.
module kfpga_config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CHAINS       = 4,
    parameter int CHAIN_LENGTH = 1024,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [CHAINS-1:0]                   bs_data,
    input  logic                                bs_valid,
    output logic                                bs_ready,
    output logic [CHAINS-1:0]                   config_data,
    output logic                                config_enable,
    output logic                                config_nreset,
    input  logic [CHAINS-1:0]                   chain_tail,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [cnt_width(CHAIN_LENGTH)-1:0]  bit_count
);

    localparam int CW  = cnt_width(CHAIN_LENGTH);
    localparam int CLW = cnt_width(CLEAR_CYCLES);
    localparam logic [CW-1:0]  LEN      = CW'(CHAIN_LENGTH);
    localparam logic [CLW-1:0] CLR_LAST = CLW'(CLEAR_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CLW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]       bit_count_q, bit_count_d;
    logic [CHAINS-1:0]   data_q, data_d;
    logic                en_q, en_d;
    logic                ready_q, ready_d;
    logic                nreset_q, nreset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                handshake;

`ifdef KFPGA_CONFIG_READBACK_EN
    logic [CW-1:0]       rb_cnt_q, rb_cnt_d;
    logic                error_q, error_d;
    logic [CHAINS-1:0]   tail_err;
    logic [CHAINS-1:0]   mismatch;

    for (genvar i = 0; i < CHAINS; i++) begin : g_chk
        kfpga_config_chain_checker #(
            .CHAIN_LENGTH(CHAIN_LENGTH)
        ) u_chk (
            .clock    (clock),
            .reset    (reset),
            .clear    (state_q == CLEAR),
            .load_en  ((state_q == LOAD) && en_q),
            .load_bit (data_q[i]),
            .rb_en    ((state_q == VERIFY) && en_q),
            .tail_bit (chain_tail[i]),
            .tail_err (tail_err[i]),
            .mismatch (mismatch[i])
        );
    end
`else
    logic unused_tail;
    assign unused_tail = ^chain_tail;
`endif

    assign handshake = bs_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        bit_count_d = bit_count_q;
        data_d      = data_q;
        en_d        = 1'b0;
`ifdef KFPGA_CONFIG_READBACK_EN
        rb_cnt_d    = rb_cnt_q;
`endif
        unique case (state_q)
            IDLE: if (start) state_d = CLEAR;
            CLEAR: begin
                if (abort)                       state_d = IDLE;
                else if (clr_cnt_q == CLR_LAST) state_d = LOAD;
                else                             clr_cnt_d = clr_cnt_q + 1'b1;
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (handshake) begin
                        data_d      = bs_data;
                        en_d        = 1'b1;
                        bit_count_d = (bit_count_q == LEN) ? LEN
                                                           : bit_count_q + 1'b1;
                    end
                    // en_q with a full count marks the last shift pulse.
`ifdef KFPGA_CONFIG_READBACK_EN
                    if (en_q && |tail_err)
                        state_d = ERROR;
                    else if (en_q && bit_count_q == LEN)
                        state_d = VERIFY;
`else
                    if (en_q && bit_count_q == LEN)
                        state_d = DONE;
`endif
                end
            end
`ifdef KFPGA_CONFIG_READBACK_EN
            VERIFY: begin
                if (abort)                  state_d = IDLE;
                else if (rb_cnt_q == LEN)   state_d = |mismatch ? ERROR : DONE;
                else                        rb_cnt_d = rb_cnt_q + 1'b1;
            end
            ERROR: begin
                if (abort)      state_d = IDLE;
                else if (start) state_d = CLEAR;
            end
`else
            VERIFY, ERROR: state_d = IDLE;
`endif
            DONE: if (start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase

        if (state_d == CLEAR && state_q != CLEAR) begin
            clr_cnt_d   = '0;
            bit_count_d = '0;
        end
`ifdef KFPGA_CONFIG_READBACK_EN
        // Recirculate for exactly CHAIN_LENGTH cycles, starting on entry.
        if (state_d == VERIFY) begin
            if (state_q != VERIFY) rb_cnt_d = '0;
            en_d = (rb_cnt_d < LEN);
        end
`endif
    end

    // Outputs are registered from the next state so they line up with it.
    assign ready_d  = (state_d == LOAD) && (bit_count_d < LEN);
    assign nreset_d = (state_d == LOAD) || (state_d == VERIFY) ||
                      (state_d == DONE);
    assign busy_d   = (state_d == CLEAR) || (state_d == LOAD) ||
                      (state_d == VERIFY);
    assign done_d   = (state_d == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            bit_count_q <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            nreset_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            bit_count_q <= bit_count_d;
            data_q      <= data_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            nreset_q    <= nreset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef KFPGA_CONFIG_READBACK_EN
    assign error_d = (state_d == ERROR);

    always_ff @(posedge clock) begin
        if (reset) begin
            rb_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            rb_cnt_q <= rb_cnt_d;
            error_q  <= error_d;
        end
    end

    // The tail feeds straight back to the head so the ring is exactly
    // CHAIN_LENGTH long and the contents come back unchanged.
    assign config_data = (state_q == VERIFY) ? chain_tail : data_q;
    assign error       = error_q;
`else
    assign config_data = data_q;
    assign error       = 1'b0;
`endif

    assign bs_ready      = ready_q;
    assign config_enable = en_q;
    assign config_nreset = nreset_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Self-checking bench for kfpga_config_loader with a behavioural
// shift-chain model attached to the config pins.
module tb_kfpga_config_loader;

    localparam int CH = 2;
    localparam int L  = 8;
    localparam int CC = 4;
    localparam int CW = $clog2(L + 1);

    logic          clock = 1'b0;
    logic          reset, start, abort, bs_valid;
    logic [CH-1:0] bs_data, config_data, chain_tail;
    logic          bs_ready, config_enable, config_nreset;
    logic          busy, done, error;
    logic [CW-1:0] bit_count;

    int checks   = 0;
    int failures = 0;

    bit            stuck = 1'b0;
    logic [L-1:0]  ch [CH];
    logic [CH-1:0] exp_q [$];
    int            hs_total;
    bit            hs_prev;

    always #5 clock = ~clock;

    kfpga_config_loader #(
        .CHAINS       (CH),
        .CHAIN_LENGTH (L),
        .CLEAR_CYCLES (CC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .bs_data       (bs_data),
        .bs_valid      (bs_valid),
        .bs_ready      (bs_ready),
        .config_data   (config_data),
        .config_enable (config_enable),
        .config_nreset (config_nreset),
        .chain_tail    (chain_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .bit_count     (bit_count)
    );

    // Behavioural config chains: cleared by nreset, shift on enable.
    always @(posedge clock) begin
        for (int i = 0; i < CH; i++) begin
            if (!config_nreset)     ch[i] <= '0;
            else if (config_enable) ch[i] <= {ch[i][L-2:0], config_data[i]};
        end
    end

    always_comb begin
        chain_tail = '0;
        for (int i = 0; i < CH; i++) chain_tail[i] = ch[i][L-1] | stuck;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then measure how long the fabric is held cleared.
    task automatic do_start();
        int nlow;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("done_falls", {31'd0, done}, 0);
        check("error_clear", {31'd0, error}, 0);
        nlow = 0;
        for (int i = 0; i < 20 && !config_nreset; i++) begin
            if (busy) nlow++;
            @(negedge clock);
        end
        check("clear_cycles", nlow, CC);
        check("load_ready", {31'd0, bs_ready}, 1);
        exp_q.delete();
        hs_total = 0;
        hs_prev  = 1'b0;
    endtask

    // mode 0: valid always, 1: every other cycle, 2: random gaps.
    task automatic run_load(input int mode, input int stop_after);
        int err;
        bit active;
        err    = 0;
        active = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (active) begin
                if (config_enable !== hs_prev) err++;
                if (hs_prev && config_data !== exp_q[$]) err++;
                if (bit_count !== CW'(hs_total)) err++;
                if (hs_total == L && hs_prev) active = 1'b0;
            end
            if (done || error) break;
            if (stop_after >= 0 && hs_total == stop_after) break;
            bs_valid = (hs_total < L) &&
                       (mode == 0 || (mode == 1 && cyc[0]) ||
                        (mode == 2 && $urandom_range(0, 1) == 1));
            bs_data  = CH'($urandom);
            hs_prev  = bs_valid && bs_ready;
            if (hs_prev) begin
                exp_q.push_back(bs_data);
                hs_total++;
            end
            @(negedge clock);
        end
        bs_valid = 1'b0;
        check("pulse_timing", err, 0);
    endtask

    task automatic check_result(input string tag);
        int bad;
        bad = 0;
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_count"}, {28'd0, bit_count}, L);
        check({tag, "_slices"}, exp_q.size(), L);
        check({tag, "_idle_pins"},
              {28'd0, bs_ready, busy, config_nreset, error}, 4'b0010);
        for (int k = 0; k < L && k < exp_q.size(); k++)
            for (int i = 0; i < CH; i++)
                if (ch[i][L-1-k] !== exp_q[k][i]) bad++;
        check({tag, "_chain"}, bad, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        bs_valid = 1'b0;
        bs_data  = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs",
              {20'd0, bs_ready, config_data, config_enable, config_nreset,
               busy, done, error, bit_count}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_nreset", {31'd0, config_nreset}, 0);

        do_start();
        run_load(0, -1);
        check_result("stream");

        do_start();
        run_load(1, -1);
        check_result("toggle");

        do_start();
        run_load(2, 3);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_pins",
              {28'd0, config_nreset, busy, done, config_enable}, 0);
        do_start();
        run_load(2, -1);
        check_result("reload");

        do_start();
        run_load(0, 3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midload_reset",
              {20'd0, bs_ready, config_data, config_enable, config_nreset,
               busy, done, error, bit_count}, 0);

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("clear_entered", {31'd0, busy}, 1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins", {30'd0, busy, config_nreset}, 0);
        @(negedge clock);
        check("stay_idle", {30'd0, busy, done}, 0);

`ifdef KFPGA_CONFIG_READBACK_EN
        stuck = 1'b1;
        do_start();
        run_load(0, -1);
        check("stuck_error", {29'd0, error, config_nreset, busy}, 3'b100);
        stuck = 1'b0;
        do_start();
        run_load(2, -1);
        check_result("after_error");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
